// File: rtl/instruction_fetch.sv
// instruction_fetch: program-ROM master that holds the PC, fetches one word per
// FETCH cycle into an instruction register and offers it downstream with a
// valid/ready handshake. Supports branch redirects, a sticky halt request and a
// saturating count of retired (handed-off) instructions.
module instruction_fetch #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [ADDR_WIDTH-1:0]  rom_address,
  output logic                   rom_cs,
  input  logic [DATA_WIDTH-1:0]  rom_data,
  output logic [DATA_WIDTH-1:0]  instr,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [ADDR_WIDTH-1:0]  pc,
  input  logic                   branch_en,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  input  logic                   halt,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID,
    HALT
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   pc_next;
  logic                    capture;
  logic                    transfer;
  logic                    halt_pending;
  logic                    halt_pending_next;
  logic                    halt_req;

  // A transfer happens whenever the held instruction is accepted downstream.
  assign transfer = (state == VALID) && instr_ready;

  // A halt may arrive while an instruction is still offered; remember it.
  assign halt_req = halt || halt_pending;

  // The ROM is addressed straight from the PC; status outputs follow the state.
  assign rom_address = pc;
  assign rom_cs      = (state == FETCH);
  assign instr_valid = (state == VALID);
  assign halted      = (state == HALT);

  // Next-state, next-PC and capture decisions for the fetch sequence.
  always_comb begin
    state_next        = state;
    pc_next           = pc;
    capture           = 1'b0;
    halt_pending_next = halt_pending;
    case (state)
      IDLE: begin
        if (branch_en) pc_next = branch_target;
        state_next = halt ? HALT : FETCH;
      end
      FETCH: begin
        if (branch_en) pc_next = branch_target;
        if (halt) begin
          state_next = HALT;
        end else if (branch_en) begin
          state_next = FETCH;
        end else begin
          capture    = 1'b1;
          state_next = VALID;
        end
      end
      VALID: begin
        if (transfer || branch_en) begin
          pc_next    = branch_en ? branch_target : pc + ADDR_WIDTH'(1);
          state_next = halt_req ? HALT : FETCH;
        end else if (halt) begin
          halt_pending_next = 1'b1;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, PC and pending-halt registers; reset restarts from RESET_PC via IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      halt_pending <= 1'b0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      halt_pending <= halt_pending_next;
    end
  end

  // Instruction register: loaded only at the end of an undisturbed FETCH cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr <= '0;
    end else if (capture) begin
      instr <= rom_data;
    end
  end

  // Retired-instruction counter: counts handshakes and sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_count <= '0;
    end else if (transfer && (retired_count != '1)) begin
      retired_count <= retired_count + COUNT_WIDTH'(1);
    end
  end

endmodule
